max_pipeline_tree: RTL and testbench

MAX_PIPELINE_TREE -- requirements
Module: max_pipeline_tree

---
 rtl/max_pipeline_tree_pkg.sv | 10 +
 rtl/max_pipeline_tree_max2.sv | 15 +
 rtl/max_pipeline_tree.sv | 86 ++++++++
 tb/tb_max_pipeline_tree.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/max_pipeline_tree_pkg.sv
// Shared constants and types for the pipelined eight-input signed maximum tree.
package max_pipeline_tree_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int VEC_LEN            = 8;
  localparam int PIPE_DEPTH         = 3;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/max_pipeline_tree_max2.sv
// Combinational signed two-operand maximum; one node of the comparison tree.
module max2
  import max_pipeline_tree_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] y
);

  // Equal operands carry the same value, so which one wins a tie is irrelevant.
  assign y = (a >= b) ? a : b;

endmodule

// File: rtl/max_pipeline_tree.sv
// Eight-input signed maximum as a 3-level comparison tree, one register stage per
// level; each stage carries a valid bit and its data only loads on valid.
module max_pipeline_tree
  import max_pipeline_tree_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_in_1,
  input  logic signed [DATA_WIDTH-1:0] data_in_2,
  input  logic signed [DATA_WIDTH-1:0] data_in_3,
  input  logic signed [DATA_WIDTH-1:0] data_in_4,
  input  logic signed [DATA_WIDTH-1:0] data_in_5,
  input  logic signed [DATA_WIDTH-1:0] data_in_6,
  input  logic signed [DATA_WIDTH-1:0] data_in_7,
  input  logic signed [DATA_WIDTH-1:0] data_in_8,
  output logic signed [DATA_WIDTH-1:0] max_out,
  output logic                         valid_out
);

  logic signed [DATA_WIDTH-1:0] din [VEC_LEN];
  logic signed [DATA_WIDTH-1:0] l1_max  [4];
  logic signed [DATA_WIDTH-1:0] s1_data [4];
  logic signed [DATA_WIDTH-1:0] l2_max  [2];
  logic signed [DATA_WIDTH-1:0] s2_data [2];
  logic signed [DATA_WIDTH-1:0] l3_max;
  logic                         s1_valid;
  logic                         s2_valid;

  assign din[0] = data_in_1;
  assign din[1] = data_in_2;
  assign din[2] = data_in_3;
  assign din[3] = data_in_4;
  assign din[4] = data_in_5;
  assign din[5] = data_in_6;
  assign din[6] = data_in_7;
  assign din[7] = data_in_8;

  for (genvar i = 0; i < 4; i++) begin : g_level1
    max2 #(.DATA_WIDTH(DATA_WIDTH)) u_max2 (
      .a(din[2*i]),
      .b(din[2*i+1]),
      .y(l1_max[i])
    );
  end

  for (genvar i = 0; i < 2; i++) begin : g_level2
    max2 #(.DATA_WIDTH(DATA_WIDTH)) u_max2 (
      .a(s1_data[2*i]),
      .b(s1_data[2*i+1]),
      .y(l2_max[i])
    );
  end

  max2 #(.DATA_WIDTH(DATA_WIDTH)) u_max2_level3 (
    .a(s2_data[0]),
    .b(s2_data[1]),
    .y(l3_max)
  );

  // Valid bits always advance; data registers hold unless their incoming valid is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      valid_out <= 1'b0;
      max_out   <= '0;
      for (int i = 0; i < 4; i++) s1_data[i] <= '0;
      for (int i = 0; i < 2; i++) s2_data[i] <= '0;
    end else begin
      s1_valid  <= valid_in;
      s2_valid  <= s1_valid;
      valid_out <= s2_valid;
      if (valid_in) begin
        for (int i = 0; i < 4; i++) s1_data[i] <= l1_max[i];
      end
      if (s1_valid) begin
        for (int i = 0; i < 2; i++) s2_data[i] <= l2_max[i];
      end
      if (s2_valid) max_out <= l3_max;
    end
  end

endmodule

// File: tb/tb_max_pipeline_tree.sv
// Directed bench for max_pipeline_tree: a queue-based latency model checked every
// cycle, plus literal expectations at the points of interest.
module tb_max_pipeline_tree;
  import max_pipeline_tree_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid_in = 1'b0;
  logic signed [7:0] stim [8];
  logic signed [7:0] max_out;
  logic              valid_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [7:0] val;
    int                due;
  } pend_t;

  pend_t             pending [$];
  int                cyc = 0;
  bit                model_live = 1'b0;
  logic              exp_valid = 1'b0;
  logic signed [7:0] exp_max = '0;

  always #5 clk = ~clk;

  max_pipeline_tree #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .data_in_1(stim[0]),
    .data_in_2(stim[1]),
    .data_in_3(stim[2]),
    .data_in_4(stim[3]),
    .data_in_5(stim[4]),
    .data_in_6(stim[5]),
    .data_in_7(stim[6]),
    .data_in_8(stim[7]),
    .max_out  (max_out),
    .valid_out(valid_out)
  );

  // Model: each accepted vector's maximum becomes visible PIPE_DEPTH-1 edges after
  // the edge that sampled it; max_out keeps the last result, reset flushes everything.
  always @(posedge clk) begin
    logic signed [7:0] mx;
    cyc++;
    if (rst) begin
      pending.delete();
      exp_valid  = 1'b0;
      exp_max    = '0;
      model_live = 1'b1;
    end else begin
      if (valid_in) begin
        mx = stim[0];
        for (int i = 1; i < 8; i++) if (stim[i] > mx) mx = stim[i];
        pending.push_back('{val: mx, due: cyc + PIPE_DEPTH - 1});
      end
      exp_valid = 1'b0;
      if (pending.size() > 0 && pending[0].due == cyc) begin
        exp_max   = pending[0].val;
        exp_valid = 1'b1;
        void'(pending.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checks++;
      if (valid_out !== exp_valid) begin
        errors++;
        $display("[TB] FAIL model_valid cyc=%0d got=%b want=%b", cyc, valid_out, exp_valid);
      end
      checks++;
      if (max_out !== exp_max) begin
        errors++;
        $display("[TB] FAIL model_max cyc=%0d got=%0d want=%0d", cyc, max_out, exp_max);
      end
    end
  end

  task automatic loadVec(input int a0, input int a1, input int a2, input int a3,
                         input int a4, input int a5, input int a6, input int a7);
    stim[0] = 8'(a0); stim[1] = 8'(a1); stim[2] = 8'(a2); stim[3] = 8'(a3);
    stim[4] = 8'(a4); stim[5] = 8'(a5); stim[6] = 8'(a6); stim[7] = 8'(a7);
  endtask

  task automatic applyStimulus(input logic v, input logic r);
    valid_in = v;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input int em);
    logic signed [7:0] em8;
    em8 = 8'(em);
    checks++;
    if (valid_out !== ev) begin
      errors++;
      $display("[TB] FAIL %s valid got=%b want=%b", name, valid_out, ev);
    end
    checks++;
    if (max_out !== em8) begin
      errors++;
      $display("[TB] FAIL %s max got=%0d want=%0d", name, max_out, em8);
    end
    checks++;
    if (exp_valid !== ev || exp_max !== em8) begin
      errors++;
      $display("[TB] FAIL %s model got=%b/%0d want=%b/%0d", name, exp_valid, exp_max, ev, em8);
    end
  endtask

  initial begin
    loadVec(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset then idle.
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("reset_idle", 1'b0, 0);
    end

    // All negative.
    loadVec(-50, -20, -100, -5, -30, -90, -10, -60);
    applyStimulus(1'b1, 1'b0);
    loadVec(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("all_negative", 1'b1, -5);

    // Extremes back-to-back.
    loadVec(-128, 0, 50, 120, -100, 50, 120, 127);
    applyStimulus(1'b1, 1'b0);
    loadVec(30, 50, -80, 120, 0, 60, 70, 110);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("b2b_first", 1'b1, 127);
    applyStimulus(1'b0, 1'b0);
    checkOutput("b2b_second", 1'b1, 120);
    applyStimulus(1'b0, 1'b0);
    checkOutput("b2b_hold", 1'b0, 120);

    // Ties.
    loadVec(7, 7, 7, 7, 7, 7, 7, 7);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("all_equal", 1'b1, 7);

    // 127 in every position, with a -128 neighbour and near-max fillers elsewhere.
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 8; i++) stim[i] = 8'(100 + i);
      stim[(p + 1) % 8] = -8'sd128;
      stim[p] = 8'sd127;
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("pos127_%0d", p), 1'b1, 127);
    end

    // Gapped stream 1,0,1.
    loadVec(10, 40, -5, 3, 0, 22, 39, -128);
    applyStimulus(1'b1, 1'b0);
    loadVec(90, 90, 90, 90, 90, 90, 90, 90);
    applyStimulus(1'b0, 1'b0);
    loadVec(-3, -7, -128, -50, -4, -100, -9, -20);
    applyStimulus(1'b1, 1'b0);
    checkOutput("gap_first", 1'b1, 40);
    applyStimulus(1'b0, 1'b0);
    checkOutput("gap_hole", 1'b0, 40);
    applyStimulus(1'b0, 1'b0);
    checkOutput("gap_second", 1'b1, -3);

    // Mid-stream reset with three vectors in flight; reset also beats a valid vector.
    loadVec(1, 2, 3, 4, 5, 6, 7, 8);
    applyStimulus(1'b1, 1'b0);
    loadVec(11, 12, 13, 14, 15, 16, 17, 18);
    applyStimulus(1'b1, 1'b0);
    loadVec(21, 22, 23, 24, 25, 26, 27, 28);
    applyStimulus(1'b1, 1'b0);
    loadVec(120, 120, 120, 120, 120, 120, 120, 120);
    applyStimulus(1'b1, 1'b1);
    checkOutput("reset_flush0", 1'b0, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("reset_flush1", 1'b0, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("reset_flush2", 1'b0, 0);
    loadVec(99, 1, 2, 3, -99, 98, 0, 5);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("after_reset_wait", 1'b0, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("after_reset", 1'b1, 99);
    applyStimulus(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
